// File: rtl/dut_ingress_fifo.sv
// Ingress buffer ahead of the DUT input port: show-ahead FIFO with a
// valid/ready handshake on both sides. Words arriving while full are
// discarded, flagged by a sticky overflow bit and counted (saturating).
module dut_ingress_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] AFULL_CMP = (AW+1)'(AFULL_LVL);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;

   logic empty, full;
   logic wr_en, rd_en, drop_en;

   // Status flags and handshake qualifiers, all from registered pointers.
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      wr_en   = in_valid && !full;
      rd_en   = !empty && out_ready;
      drop_en = in_valid && full;
   end

   // Next-state for pointers, occupancy and drop accounting.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (drop_en) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
      // Modulo 2^(AW+1) difference; the wrap bit makes DEPTH representable.
      count_d = wr_ptr_d - rd_ptr_d;
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is not reset; stale entries are hidden while out_valid is low.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

   assign in_ready    = !full;
   assign out_valid   = !empty;
   assign out_data    = mem_q[rd_ptr_q[AW-1:0]];
   assign count       = count_q;
   assign almost_full = (count_q >= AFULL_CMP);
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_dut_ingress_fifo.sv
// Self-checking bench for dut_ingress_fifo: scoreboard queue for data,
// reference occupancy/drop model for status outputs.
module tb_dut_ingress_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AFULL  = 12;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [4:0] count;
   logic       almost_full;
   logic       overflow;
   logic [7:0] drop_cnt;

   int checks;
   int passes;

   logic [7:0] exp_q [$];
   int         m_cnt;
   int         m_drop;
   logic       m_ovf;

   dut_ingress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      exp_q.delete();
      m_cnt  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
   endtask

   // Drive one cycle of stimulus, pop/compare the scoreboard on a read,
   // push on an accepted write, then step to #1 after the next edge.
   task automatic drive_cycle(input logic iv, input logic [7:0] id, input logic ordy);
      logic rd, wr, drop;
      logic [7:0] exp_w;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      rd   = ordy && (m_cnt != 0);
      wr   = iv && (m_cnt != DEPTH);
      drop = iv && (m_cnt == DEPTH);
      if (rd) begin
         exp_w = exp_q.pop_front();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_w)
            $display("FAIL sb_data: got valid=%b data=%h, want valid=1 data=%h", out_valid, out_data, exp_w);
         else
            passes++;
      end
      if (wr) exp_q.push_back(id);
      m_cnt = m_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
      if (drop) begin
         m_ovf = 1'b1;
         if (m_drop != 255) m_drop++;
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic apply_reset();
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      #2 reset  = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset  = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      reset     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, count, almost_full, overflow, drop_cnt} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0})
         $display("FAIL reset_hold: got rdy=%b vld=%b cnt=%0d af=%b ovf=%b drop=%0d, want 1 0 0 0 0 0",
                  in_ready, out_valid, count, almost_full, overflow, drop_cnt);
      else passes++;
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, count, almost_full, overflow, drop_cnt} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0})
         $display("FAIL reset_release: got rdy=%b vld=%b cnt=%0d af=%b ovf=%b drop=%0d, want 1 0 0 0 0 0",
                  in_ready, out_valid, count, almost_full, overflow, drop_cnt);
      else passes++;
   endtask

   task automatic test_single();
      drive_cycle(1'b1, 8'hA5, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 5'd1)
         $display("FAIL single_write: got vld=%b data=%h cnt=%0d, want 1 a5 1", out_valid, out_data, count);
      else passes++;
      drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || count !== 5'd0)
         $display("FAIL single_read: got vld=%b cnt=%0d, want 0 0", out_valid, count);
      else passes++;
   endtask

   task automatic test_fill_drop();
      int af_err;
      int rdy_err;
      af_err  = 0;
      rdy_err = 0;
      for (int i = 0; i < 19; i++) begin
         drive_cycle(1'b1, 8'(i), 1'b0);
         if (almost_full !== ((i + 1) >= AFULL)) af_err++;
         if (in_ready !== ((i + 1) < DEPTH)) rdy_err++;
      end
      checks++;
      if (af_err != 0) $display("FAIL fill_almost_full: got %0d bad cycles, want 0", af_err);
      else passes++;
      checks++;
      if (rdy_err != 0) $display("FAIL fill_in_ready: got %0d bad cycles, want 0", rdy_err);
      else passes++;
      checks++;
      if (drop_cnt !== 8'd3 || overflow !== 1'b1 || count !== 5'd16)
         $display("FAIL fill_drops: got drop=%0d ovf=%b cnt=%0d, want 3 1 16", drop_cnt, overflow, count);
      else passes++;
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || count !== 5'd0 || exp_q.size() != 0)
         $display("FAIL fill_drain: got vld=%b cnt=%0d left=%0d, want 0 0 0", out_valid, count, exp_q.size());
      else passes++;
   endtask

   task automatic test_stream_wrap();
      int cnt_err;
      cnt_err = 0;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1'b1, 8'(8'h40 + i), 1'b1);
         if (count > 5'd1 || 32'(count) != m_cnt) cnt_err++;
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (cnt_err != 0) $display("FAIL stream_count: got %0d bad cycles, want 0", cnt_err);
      else passes++;
      checks++;
      if (drop_cnt !== 8'd0 || out_valid !== 1'b0 || exp_q.size() != 0)
         $display("FAIL stream_end: got drop=%0d vld=%b left=%0d, want 0 0 0", drop_cnt, out_valid, exp_q.size());
      else passes++;
   endtask

   task automatic test_full_rw();
      apply_reset();
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0);
      checks++;
      if (in_ready !== 1'b0 || count !== 5'd16 || drop_cnt !== 8'd0)
         $display("FAIL full_state: got rdy=%b cnt=%0d drop=%0d, want 0 16 0", in_ready, count, drop_cnt);
      else passes++;
      drive_cycle(1'b1, 8'hEE, 1'b1);
      checks++;
      if (count !== 5'd15 || drop_cnt !== 8'd1 || overflow !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL full_rw: got cnt=%0d drop=%0d ovf=%b rdy=%b, want 15 1 1 1", count, drop_cnt, overflow, in_ready);
      else passes++;
      for (int i = 0; i < 15; i++) drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0)
         $display("FAIL full_rw_drain: got left=%0d vld=%b, want 0 0", exp_q.size(), out_valid);
      else passes++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < DEPTH + 5; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      for (int i = 0; i < 9; i++) drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (count !== 5'd7 || drop_cnt !== 8'd5)
         $display("FAIL mid_setup: got cnt=%0d drop=%0d, want 7 5", count, drop_cnt);
      else passes++;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 5'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mid_async_clear: got vld=%b cnt=%0d drop=%0d ovf=%b rdy=%b, want 0 0 0 0 1",
                  out_valid, count, drop_cnt, overflow, in_ready);
      else passes++;
      #1 reset = 1'b1;
      model_clear();
      drive_cycle(1'b1, 8'h5A, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 5'd1)
         $display("FAIL mid_rewrite: got vld=%b data=%h cnt=%0d, want 1 5a 1", out_valid, out_data, count);
      else passes++;
      drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || count !== 5'd0)
         $display("FAIL mid_reread: got vld=%b cnt=%0d, want 0 0", out_valid, count);
      else passes++;
   endtask

   initial begin
      checks    = 0;
      passes    = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      model_clear();
      test_reset();
      test_single();
      test_fill_drop();
      test_stream_wrap();
      test_full_rw();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
